// File: rtl/lfsr_checker_if.sv
// Sample/status bundle for lfsr_checker.
// master: the side feeding samples and reading status; slave: the checker.
interface lfsr_checker_if;
    logic        in_valid;
    logic [7:0]  data_in;
    logic        clear;
    logic        locked;
    logic        error_pulse;
    logic        sync_loss;
    logic [15:0] error_count;
    logic [31:0] sample_count;

    modport master (
        output in_valid, data_in, clear,
        input  locked, error_pulse, sync_loss, error_count, sample_count
    );

    modport slave (
        input  in_valid, data_in, clear,
        output locked, error_pulse, sync_loss, error_count, sample_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires and tracks an 8-bit LFSR byte stream
// (x^8+x^6+x^5+x^4+1), counting mismatches once locked.
// Optional feature: define LFSR_CHECKER_STATS_EN to build the 32-bit
// sample_count counter; without it sample_count reads constant 0.
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input logic          clk,
    input logic          resetn,
    lfsr_checker_if.slave bus
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    state_t      state;
    logic [7:0]  prev;
    logic        prev_valid;
    logic [7:0]  expected;
    logic [3:0]  match_cnt;
    logic [3:0]  consec_err;
    logic        locked_q;
    logic        error_pulse_q;
    logic        sync_loss_q;
    logic [15:0] error_count_q;
    logic [31:0] sample_count_q;

    // Acquisition/tracking FSM with registered status outputs and error counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= SEARCH;
            prev          <= '0;
            prev_valid    <= 1'b0;
            expected      <= '0;
            match_cnt     <= '0;
            consec_err    <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            sync_loss_q   <= 1'b0;
            error_count_q <= '0;
        end else begin
            error_pulse_q <= 1'b0;
            sync_loss_q   <= 1'b0;
            if (bus.in_valid) begin
                unique case (state)
                    SEARCH: begin
                        prev       <= bus.data_in;
                        prev_valid <= 1'b1;
                        // A zero byte is the LFSR lock-up state and would
                        // otherwise self-match forever; the first sample
                        // after reset/loss has nothing to compare against.
                        if (bus.data_in == '0 || !prev_valid) begin
                            match_cnt <= '0;
                        end else if (bus.data_in == lfsr_next(prev)) begin
                            if (match_cnt + 4'd1 == LOCK_CNT) begin
                                state      <= LOCKED;
                                locked_q   <= 1'b1;
                                expected   <= lfsr_next(bus.data_in);
                                match_cnt  <= '0;
                                consec_err <= '0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running prediction: a corrupted byte never
                        // seeds the next expected value.
                        expected <= lfsr_next(expected);
                        if (bus.data_in == expected) begin
                            consec_err <= '0;
                        end else begin
                            error_pulse_q <= 1'b1;
                            if (error_count_q != '1) begin
                                error_count_q <= error_count_q + 16'd1;
                            end
                            if (consec_err + 4'd1 == LOSS_CNT) begin
                                state       <= SEARCH;
                                locked_q    <= 1'b0;
                                sync_loss_q <= 1'b1;
                                consec_err  <= '0;
                                match_cnt   <= '0;
                                prev        <= bus.data_in;
                                prev_valid  <= 1'b1;
                            end else begin
                                consec_err <= consec_err + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any increment made above in the same cycle.
            if (bus.clear) begin
                error_count_q <= '0;
            end
        end
    end

`ifdef LFSR_CHECKER_STATS_EN
    // Wrapping count of valid samples checked while locked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_count_q <= '0;
        end else if (bus.clear) begin
            sample_count_q <= '0;
        end else if (bus.in_valid && state == LOCKED) begin
            sample_count_q <= sample_count_q + 32'd1;
        end
    end
`else
    assign sample_count_q = '0;
`endif

    assign bus.locked       = locked_q;
    assign bus.error_pulse  = error_pulse_q;
    assign bus.sync_loss    = sync_loss_q;
    assign bus.error_count  = error_count_q;
    assign bus.sample_count = sample_count_q;

endmodule
